// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
//
// Multi-cycle sequencer for the 8-bit processor core. Runs the
// fetch / decode / execute / writeback loop: owns the program counter,
// requests instruction words from instruction memory, pulses the IR load,
// starts the ALU (waiting on it for multi-cycle opcodes) and strobes the
// register-file write enable.
//
// Parameters
//   PC_WIDTH     program counter width; PC wraps modulo 2**PC_WIDTH
//   HALT_OPCODE  opcode that stops sequencing
//   NOP_OPCODE   opcode that skips execute and writeback
//   MC_MASK      bit k set -> opcode k is multi-cycle (waits for i_alu_done)
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   i_start        level; leave IDLE/HALT and begin fetching
//   i_imem_ready   instruction memory data valid for o_pc this cycle
//   i_opcode       opcode from decoder, valid from DECODE onward
//   i_alu_done     multi-cycle ALU result valid (single-cycle pulse)
//   o_pc           program counter / instruction address
//   o_imem_req     instruction fetch request (high only in FETCH)
//   o_ir_load      1-cycle pulse: capture instruction word into IR
//   o_alu_start    1-cycle pulse on EXECUTE entry
//   o_reg_we       1-cycle register-file write enable
//   o_busy         high in any state except IDLE and HALT
//   o_halted       high while in HALT
//   o_state        current state encoding (debug)
//
// Handshake: o_imem_req is a level request held for as long as the FSM sits
// in FETCH; a fetch completes on the first rising edge where both
// o_imem_req and i_imem_ready are high, and there is no timeout. i_alu_done
// is only observed in WAIT_ALU; a pulse in any other state is dropped.
// ---------------------------------------------------------------------------
module cpu_control_fsm #(
    parameter int          PC_WIDTH    = 8,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [3:0]  NOP_OPCODE  = 4'h0,
    parameter logic [15:0] MC_MASK     = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic                i_imem_ready,
    input  logic [3:0]          i_opcode,
    input  logic                i_alu_done,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic                o_imem_req,
    output logic                o_ir_load,
    output logic                o_alu_start,
    output logic                o_reg_we,
    output logic                o_busy,
    output logic                o_halted,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WAIT_ALU  = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic                imem_req_nxt;
    logic                ir_load_nxt;
    logic                alu_start_nxt;
    logic                reg_we_nxt;
    logic                busy_nxt;
    logic                halted_nxt;

    // -----------------------------------------------------------------------
    // State and output registers. Every output is a flop loaded from the
    // next-state view, so each one lines up exactly with the state it
    // belongs to and nothing combinational reaches the ports.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            o_pc        <= '0;
            o_imem_req  <= 1'b0;
            o_ir_load   <= 1'b0;
            o_alu_start <= 1'b0;
            o_reg_we    <= 1'b0;
            o_busy      <= 1'b0;
            o_halted    <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_pc        <= pc_nxt;
            o_imem_req  <= imem_req_nxt;
            o_ir_load   <= ir_load_nxt;
            o_alu_start <= alu_start_nxt;
            o_reg_we    <= reg_we_nxt;
            o_busy      <= busy_nxt;
            o_halted    <= halted_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = o_pc;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                // PC is held while memory stalls; no timeout.
                if (i_imem_ready) begin
                    state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                if (i_opcode == HALT_OPCODE) begin
                    // PC left on the HALT so a debugger sees where it stopped.
                    state_nxt = S_HALT;
                end else if (i_opcode == NOP_OPCODE) begin
                    pc_nxt    = o_pc + PC_ONE;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                // The decoder holds the IR, so i_opcode is still the
                // instruction being executed here.
                if (MC_MASK[i_opcode]) begin
                    state_nxt = S_WAIT_ALU;
                end else begin
                    state_nxt = S_WRITEBACK;
                end
            end

            S_WAIT_ALU: begin
                if (i_alu_done) begin
                    state_nxt = S_WRITEBACK;
                end
            end

            S_WRITEBACK: begin
                pc_nxt    = o_pc + PC_ONE;
                state_nxt = S_FETCH;
            end

            S_HALT: begin
                // Resume at the instruction after the HALT.
                if (i_start) begin
                    pc_nxt    = o_pc + PC_ONE;
                    state_nxt = S_FETCH;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs derived from where the FSM is going, registered above.
        imem_req_nxt  = (state_nxt == S_FETCH);
        ir_load_nxt   = (state == S_FETCH) && (state_nxt == S_DECODE);
        alu_start_nxt = (state_nxt == S_EXECUTE);
        reg_we_nxt    = (state_nxt == S_WRITEBACK);
        busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_HALT);
        halted_nxt    = (state_nxt == S_HALT);
    end

    assign o_state = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_fsm
//
// Directed bench for cpu_control_fsm. A small instruction memory array plays
// the decoder: i_opcode is the entry at o_pc. One linear sequence walks
// reset, a two-ADD-then-HALT program, a stalled fetch, a multi-cycle ALU op,
// a NOP, HALT resume, a NOP stream across the PC wrap and a reset landing in
// WAIT_ALU.
// ---------------------------------------------------------------------------
module tb_cpu_control_fsm;

  localparam int PW = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_WB = 3'd5;
  localparam logic [2:0] ST_HALT = 3'd6;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic          i_imem_ready;
  logic [3:0]    i_opcode;
  logic          i_alu_done;
  logic [PW-1:0] o_pc;
  logic          o_imem_req;
  logic          o_ir_load;
  logic          o_alu_start;
  logic          o_reg_we;
  logic          o_busy;
  logic          o_halted;
  logic [2:0]    o_state;

  logic [3:0] prog [256];

  int total;
  int bad;

  cpu_control_fsm #(
    .PC_WIDTH   (PW),
    .HALT_OPCODE(4'hF),
    .NOP_OPCODE (4'h0),
    .MC_MASK    (16'h0004)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_imem_ready(i_imem_ready),
    .i_opcode    (i_opcode),
    .i_alu_done  (i_alu_done),
    .o_pc        (o_pc),
    .o_imem_req  (o_imem_req),
    .o_ir_load   (o_ir_load),
    .o_alu_start (o_alu_start),
    .o_reg_we    (o_reg_we),
    .o_busy      (o_busy),
    .o_halted    (o_halted),
    .o_state     (o_state)
  );

  assign i_opcode = prog[o_pc];

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance one cycle; return 1 time unit after the edge so outputs settled
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] exp_st1 [11];
    logic [2:0] nop_st [4];
    logic [7:0] nop_pc [4];
    int         req_cnt;
    bit         found;
    bit         saw_we;

    total = 0;
    bad = 0;
    exp_st1 = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_FETCH, ST_DECODE,
                ST_EXEC, ST_WB, ST_FETCH, ST_DECODE, ST_HALT};
    nop_st = '{ST_DECODE, ST_FETCH, ST_DECODE, ST_FETCH};
    nop_pc = '{8'hFE, 8'hFF, 8'hFF, 8'h00};

    // program: ADD, ADD, HALT, MC op 2, NOP, HALT, then NOPs to the top
    for (int i = 0; i < 256; i++) prog[i] = 4'h0;
    prog[0] = 4'h1;
    prog[1] = 4'h1;
    prog[2] = 4'hF;
    prog[3] = 4'h2;
    prog[4] = 4'h0;
    prog[5] = 4'hF;

    reset = 1'b1;
    i_start = 1'b0;
    i_imem_ready = 1'b1;
    i_alu_done = 1'b0;

    // ---- reset state ----
    step();
    step();
    chk("rst_state", o_state, ST_IDLE);
    chk("rst_pc", o_pc, 0);
    chk("rst_outs", {o_imem_req, o_ir_load, o_alu_start, o_reg_we, o_busy, o_halted}, 0);

    // ---- ADD, ADD, HALT with zero-wait memory ----
    reset = 1'b0;
    i_start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      i_start = 1'b0;
      chk($sformatf("p1_state_c%0d", c), o_state, exp_st1[c-1]);
      chk($sformatf("p1_we_c%0d", c), o_reg_we, (c == 4 || c == 8));
      if (c == 1) chk("p1_busy_c1", o_busy, 1);
      if (c == 2) chk("p1_irload_c2", o_ir_load, 1);
      if (c == 3) chk("p1_alustart_c3", o_alu_start, 1);
      if (c == 5) chk("p1_pc_c5", o_pc, 1);
    end
    chk("p1_halted", o_halted, 1);
    chk("p1_halt_pc", o_pc, 2);
    chk("p1_halt_busy", o_busy, 0);
    prog[0] = 4'h2;  // later re-entry at PC 0 runs a multi-cycle op

    // ---- resume from HALT into a stalled fetch ----
    i_imem_ready = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("stall_pc_resume", o_pc, 3);
    req_cnt = 0;
    if (o_imem_req) req_cnt++;
    for (int k = 2; k <= 6; k++) begin
      step();
      if (o_imem_req) req_cnt++;
      chk($sformatf("stall_state_f%0d", k), o_state, ST_FETCH);
      chk($sformatf("stall_irload_f%0d", k), o_ir_load, 0);
      chk($sformatf("stall_pc_f%0d", k), o_pc, 3);
    end
    i_imem_ready = 1'b1;
    step();
    if (o_imem_req) req_cnt++;
    chk("stall_req_cycles", req_cnt, 6);
    chk("stall_irload", o_ir_load, 1);
    chk("stall_decode", o_state, ST_DECODE);
    step();
    chk("stall_irload_once", o_ir_load, 0);

    // ---- multi-cycle opcode 2, done after 7 WAIT_ALU cycles ----
    chk("mc_exec", o_state, ST_EXEC);
    chk("mc_alustart", o_alu_start, 1);
    step();
    chk("mc_wait_w1", o_state, ST_WAIT);
    chk("mc_alustart_drop", o_alu_start, 0);
    for (int w = 2; w <= 7; w++) begin
      step();
      chk($sformatf("mc_wait_w%0d", w), o_state, ST_WAIT);
      chk($sformatf("mc_we_w%0d", w), o_reg_we, 0);
    end
    i_alu_done = 1'b1;
    step();
    i_alu_done = 1'b0;
    chk("mc_wb_state", o_state, ST_WB);
    chk("mc_we", o_reg_we, 1);
    step();
    chk("mc_we_once", o_reg_we, 0);
    chk("mc_pc", o_pc, 4);

    // ---- NOP at 4, HALT at 5 ----
    step();
    chk("nop4_decode", o_state, ST_DECODE);
    step();
    chk("nop4_pc", o_pc, 5);
    step();
    step();
    chk("halt5_state", o_state, ST_HALT);
    chk("halt5_pc", o_pc, 5);

    // ---- HALT resume; i_start held through FETCH is ignored ----
    i_imem_ready = 1'b0;
    i_start = 1'b1;
    step();
    chk("resume_state", o_state, ST_FETCH);
    chk("resume_pc", o_pc, 6);
    step();
    step();
    chk("start_in_fetch_state", o_state, ST_FETCH);
    chk("start_in_fetch_pc", o_pc, 6);
    i_start = 1'b0;
    i_imem_ready = 1'b1;

    // ---- NOP stream up to FE, then across the wrap ----
    found = 1'b0;
    saw_we = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      if (o_pc == 8'hFE && o_state == ST_FETCH) found = 1'b1;
      else begin
        step();
        if (o_reg_we) saw_we = 1'b1;
      end
    end
    chk("nop_reach_fe", found, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_reg_we) saw_we = 1'b1;
      chk($sformatf("wrap_state_%0d", i), o_state, nop_st[i]);
      chk($sformatf("wrap_pc_%0d", i), o_pc, nop_pc[i]);
    end
    chk("nop_no_we", saw_we, 0);

    // ---- reset landing in WAIT_ALU ----
    step();
    step();
    step();
    step();
    chk("rw_in_wait", o_state, ST_WAIT);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_async_state", o_state, ST_IDLE);
    chk("rw_async_pc", o_pc, 0);
    step();
    reset = 1'b0;
    i_alu_done = 1'b1;
    saw_we = 1'b0;
    step();
    i_alu_done = 1'b0;
    if (o_reg_we) saw_we = 1'b1;
    step();
    if (o_reg_we) saw_we = 1'b1;
    chk("rw_idle", o_state, ST_IDLE);
    chk("rw_pc", o_pc, 0);
    chk("rw_no_we", saw_we, 0);
    chk("rw_not_busy", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
